ula_multiciclo: RTL and testbench

- Parametrised, registered successor to the single-cycle datapath ALU. Adds multi-cycle shift and multiply ops and a start/done handshake.
- Sits between the register-file read stage and the write-back mux. The control FSM asserts `inicio` and waits for `pronto`.
- Zero flag is valid for every op, not only subtraction.

---
 rtl/ula_pkg.sv | 12 +
 rtl/ula_mult_seq.sv | 53 +++++
 rtl/ula_multiciclo.sv | 148 ++++++++++++++
 tb/tb_ula_multiciclo.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: operation codes and control-state encoding shared by the multi-cycle ALU
package ula_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_INV = 3'b111;
  typedef enum logic [1:0] {OCIOSO = 2'd0, CALCULA = 2'd1, FIM = 2'd2} estado_t;
endpackage

// File: rtl/ula_mult_seq.sv
// ula_mult_seq: iterative signed shift-add multiplier; carregar does bit 0, each passo one more bit
// With ULA_OVERFLOW_EN the full 2*LARGURA product is kept, otherwise only the low LARGURA bits.
module ula_mult_seq #(
  parameter int LARGURA = 8,
`ifdef ULA_OVERFLOW_EN
  localparam int PW = 2 * LARGURA
`else
  localparam int PW = LARGURA
`endif
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      carregar,
  input  logic signed [LARGURA-1:0] A,
  input  logic signed [LARGURA-1:0] B,
  input  logic                      passo,
  output logic [PW-1:0]             produto
);
  logic [PW-1:0] acc_q, acc_d, a_q, a_d;
  logic [LARGURA-1:0] b_q, b_d, m_q, m_d;
  // the multiplier MSB carries negative weight, so the last bit subtracts
  always_comb begin
    acc_d = acc_q;
    a_d = a_q;
    b_d = b_q;
    m_d = m_q;
    if (carregar) begin
      acc_d = B[0] ? PW'(A) : '0;
      a_d = PW'(A) << 1;
      b_d = B >> 1;
      m_d = LARGURA'(2);
    end else if (passo) begin
      acc_d = b_q[0] ? (m_q[LARGURA-1] ? acc_q - a_q : acc_q + a_q) : acc_q;
      a_d = a_q << 1;
      b_d = b_q >> 1;
      m_d = m_q << 1;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      m_q <= '0;
    end else begin
      acc_q <= acc_d;
      a_q <= a_d;
      b_q <= b_d;
      m_q <= m_d;
    end
  end
  assign produto = acc_q;
endmodule

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: registered ALU with start/done handshake and multi-cycle sll/mul
// Define ULA_OVERFLOW_EN to add the Overflow output.
module ula_multiciclo import ula_pkg::*; #(
  parameter int LARGURA = 8,
  parameter int SHW = $clog2(LARGURA)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      inicio,
  input  logic [2:0]                ULAOp,
  input  logic signed [LARGURA-1:0] Operando1,
  input  logic signed [LARGURA-1:0] Operando2,
  output logic                      ocupado,
  output logic                      pronto,
  output logic                      Zero,
  output logic [LARGURA-1:0]        SaidaULA
`ifdef ULA_OVERFLOW_EN
  ,
  output logic                      Overflow
`endif
);
  localparam int CW = SHW + 1;
`ifdef ULA_OVERFLOW_EN
  localparam int PW = 2 * LARGURA;
`else
  localparam int PW = LARGURA;
`endif
  localparam int M = LARGURA - 1;
  estado_t estado_q, estado_d;
  logic [2:0] op_q, op_d;
  logic [LARGURA-1:0] sh_q, sh_d, res_q, res_d, soma, dif, imm, fim_res;
  logic [CW-1:0] cnt_q, cnt_d;
  logic zero_q, zero_d, pronto_q, pronto_d, ocup_q, ocup_d, aceita, carregar, passo;
  logic [PW-1:0] produto;
`ifdef ULA_OVERFLOW_EN
  logic ov_q, ov_d, ov_imm, ov_mul;
`endif
  ula_mult_seq #(.LARGURA(LARGURA)) u_mult (
    .clock(clock),
    .reset(reset),
    .carregar(carregar),
    .A(Operando1),
    .B(Operando2),
    .passo(passo),
    .produto(produto)
  );
  always_comb begin
    soma = Operando1 + Operando2;
    dif = Operando1 - Operando2;
    imm = ULAOp == OP_ADD ? soma :
          ULAOp == OP_SUB ? dif :
          ULAOp == OP_SLT ? LARGURA'(Operando1 < Operando2) :
          ULAOp == OP_AND ? Operando1 & Operando2 :
          ULAOp == OP_OR  ? Operando1 | Operando2 :
          ULAOp == OP_SLL ? Operando1 : '0;
    fim_res = op_q == OP_MUL ? produto[LARGURA-1:0] : sh_q << 1;
    aceita = inicio && estado_q != CALCULA;
`ifdef ULA_OVERFLOW_EN
    ov_imm = ULAOp == OP_ADD ? (Operando1[M] == Operando2[M] && soma[M] != Operando1[M]) :
             ULAOp == OP_SUB ? (Operando1[M] != Operando2[M] && dif[M] != Operando1[M]) : 1'b0;
    ov_mul = !(&produto[PW-1:M]) && |produto[PW-1:M];
    ov_d = ov_q;
`endif
    estado_d = estado_q;
    op_d = op_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    res_d = res_q;
    zero_d = zero_q;
    pronto_d = 1'b0;
    ocup_d = 1'b0;
    carregar = 1'b0;
    passo = 1'b0;
    if (aceita) begin
      op_d = ULAOp;
      sh_d = Operando1;
      if (ULAOp == OP_MUL) begin
        carregar = 1'b1;
        cnt_d = CW'(LARGURA);
        estado_d = CALCULA;
        ocup_d = 1'b1;
      end else if (ULAOp == OP_SLL && Operando2[SHW-1:0] != '0) begin
        cnt_d = CW'(Operando2[SHW-1:0]);
        estado_d = CALCULA;
        ocup_d = 1'b1;
      end else begin
        estado_d = FIM;
        pronto_d = 1'b1;
        res_d = imm;
        zero_d = ULAOp != OP_INV && imm == '0;
`ifdef ULA_OVERFLOW_EN
        ov_d = ov_imm;
`endif
      end
    end else if (estado_q == CALCULA) begin
      cnt_d = cnt_q - CW'(1);
      sh_d = sh_q << 1;
      passo = op_q == OP_MUL && cnt_q != CW'(1);
      if (cnt_q == CW'(1)) begin
        estado_d = FIM;
        pronto_d = 1'b1;
        res_d = fim_res;
        zero_d = fim_res == '0;
`ifdef ULA_OVERFLOW_EN
        ov_d = op_q == OP_MUL && ov_mul;
`endif
      end else begin
        ocup_d = 1'b1;
      end
    end else if (estado_q == FIM) begin
      estado_d = OCIOSO;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      op_q <= '0;
      sh_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      zero_q <= 1'b0;
      pronto_q <= 1'b0;
      ocup_q <= 1'b0;
`ifdef ULA_OVERFLOW_EN
      ov_q <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
      op_q <= op_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      zero_q <= zero_d;
      pronto_q <= pronto_d;
      ocup_q <= ocup_d;
`ifdef ULA_OVERFLOW_EN
      ov_q <= ov_d;
`endif
    end
  end
  assign ocupado = ocup_q;
  assign pronto = pronto_q;
  assign Zero = zero_q;
  assign SaidaULA = res_q;
`ifdef ULA_OVERFLOW_EN
  assign Overflow = ov_q;
`endif
endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: randomized and directed checks against a cycle-level behavioural model
module tb_ula_multiciclo;
  localparam int L = 8;
  logic clock = 0, reset = 1, inicio = 0;
  logic [2:0] ULAOp = 0;
  logic signed [L-1:0] Operando1 = 0, Operando2 = 0;
  logic ocupado, pronto, Zero;
  logic [L-1:0] SaidaULA;
`ifdef ULA_OVERFLOW_EN
  logic Overflow;
`endif
  int checks = 0, errors = 0;
  ula_multiciclo #(.LARGURA(L)) dut (
    .clock(clock),
    .reset(reset),
    .inicio(inicio),
    .ULAOp(ULAOp),
    .Operando1(Operando1),
    .Operando2(Operando2),
    .ocupado(ocupado),
    .pronto(pronto),
    .Zero(Zero),
    .SaidaULA(SaidaULA)
`ifdef ULA_OVERFLOW_EN
    ,
    .Overflow(Overflow)
`endif
  );
  always #5 clock = ~clock;
  typedef struct {
    int left;
    logic [L-1:0] pres, res;
    logic pz, pov, zero, ov, pronto, ocup;
  } mdl_t;
  mdl_t m = '{default: 0};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  function automatic void golden(input logic [2:0] op, input logic [L-1:0] a, input logic [L-1:0] b,
                                 output logic [L-1:0] r, output logic z, output logic ov, output int lat);
    int sa, sb, full;
    sa = int'($signed(a));
    sb = int'($signed(b));
    full = 0;
    lat = 1;
    case (op)
      3'd0: full = sa + sb;
      3'd1: full = sa - sb;
      3'd2: full = (sa < sb) ? 1 : 0;
      3'd3: full = int'(a & b);
      3'd4: full = int'(a | b);
      3'd5: begin full = int'(a) << (int'(b) % L); lat = int'(b) % L + 1; end
      3'd6: begin full = sa * sb; lat = L + 1; end
      default: full = 0;
    endcase
    r = L'(full);
    z = (op != 3'd7) && (r == 0);
    ov = (op == 3'd0 || op == 3'd1 || op == 3'd6) && (full > 2 ** (L - 1) - 1 || full < -(2 ** (L - 1)));
  endfunction
  function automatic mdl_t step(input mdl_t s, input logic ini, input logic [2:0] op,
                                input logic [L-1:0] a, input logic [L-1:0] b);
    mdl_t n;
    logic fire, z, ov;
    logic [L-1:0] r;
    int lat;
    n = s;
    fire = 0;
    if (s.left == 0 && ini) begin
      golden(op, a, b, r, z, ov, lat);
      n.pres = r;
      n.pz = z;
      n.pov = ov;
      n.left = lat - 1;
      fire = n.left == 0;
    end else if (s.left > 0) begin
      n.left = s.left - 1;
      fire = n.left == 0;
    end
    n.ocup = n.left > 0;
    n.pronto = fire;
    if (fire) begin
      n.res = n.pres;
      n.zero = n.pz;
      n.ov = n.pov;
    end
    return n;
  endfunction
  always @(posedge clock or posedge reset)
    if (reset) m <= '{default: 0};
    else m <= step(m, inicio, ULAOp, Operando1, Operando2);
  always @(negedge clock)
    if (!reset) begin
      chk("pronto", pronto, m.pronto);
      chk("ocupado", ocupado, m.ocup);
      chk("SaidaULA", SaidaULA, m.res);
      chk("Zero", Zero, m.zero);
`ifdef ULA_OVERFLOW_EN
      chk("Overflow", Overflow, m.ov);
`endif
    end
  task automatic do_op(input string nm, input logic [2:0] op, input logic [L-1:0] a, input logic [L-1:0] b,
                       input logic [L-1:0] er, input logic ez, input int elat, input int pa, input int pb,
                       output int oc);
    int lat;
    ULAOp = op;
    Operando1 = a;
    Operando2 = b;
    inicio = 1;
    @(negedge clock);
    inicio = 0;
    lat = 1;
    oc = 0;
    while (!pronto && lat < 40) begin
      oc += int'(ocupado);
      inicio = (lat == pa || lat == pb);
      ULAOp = 3'($urandom);
      Operando1 = L'($urandom);
      Operando2 = L'($urandom);
      @(negedge clock);
      lat++;
    end
    inicio = 0;
    chk({nm, " latency"}, lat, elat);
    chk({nm, " result"}, SaidaULA, er);
    chk({nm, " zero"}, Zero, ez);
  endtask
  initial begin
    int oc;
    repeat (2) @(negedge clock);
    chk("reset SaidaULA", SaidaULA, 0);
    chk("reset Zero", Zero, 0);
    chk("reset pronto", pronto, 0);
    chk("reset ocupado", ocupado, 0);
    reset = 0;
    ULAOp = 3'd6;
    Operando1 = 8'h05;
    Operando2 = 8'h03;
    inicio = 1;
    @(negedge clock);
    inicio = 0;
    repeat (3) @(negedge clock);
    chk("mid mul busy", ocupado, 1);
    reset = 1;
    #1;
    chk("abort SaidaULA", SaidaULA, 0);
    chk("abort Zero", Zero, 0);
    chk("abort pronto", pronto, 0);
    chk("abort ocupado", ocupado, 0);
    @(negedge clock);
    reset = 0;
    repeat (10) begin
      @(negedge clock);
      chk("no pronto after abort", pronto, 0);
    end
    do_op("add", 3'd0, 8'h03, 8'h04, 8'h07, 0, 1, 0, 0, oc);
    do_op("sub eq", 3'd1, 8'h25, 8'h25, 8'h00, 1, 1, 0, 0, oc);
    do_op("sub neg", 3'd1, 8'h10, 8'h20, 8'hF0, 0, 1, 0, 0, oc);
    do_op("slt neg", 3'd2, 8'h80, 8'h01, 8'h01, 0, 1, 0, 0, oc);
    do_op("slt pos", 3'd2, 8'h01, 8'h80, 8'h00, 1, 1, 0, 0, oc);
    do_op("sll 3", 3'd5, 8'h03, 8'h03, 8'h18, 0, 4, 0, 0, oc);
    chk("sll busy cycles", oc, 3);
    do_op("sll 0", 3'd5, 8'h03, 8'h00, 8'h03, 0, 1, 0, 0, oc);
    do_op("mul", 3'd6, 8'h05, 8'hFD, 8'hF1, 0, 9, 3, 5, oc);
    chk("mul busy cycles", oc, 8);
`ifdef ULA_OVERFLOW_EN
    do_op("mul ovf", 3'd6, 8'h40, 8'h04, 8'h00, 1, 9, 0, 0, oc);
    chk("mul ovf flag", Overflow, 1);
`endif
    ULAOp = 3'd0;
    Operando1 = 8'h01;
    Operando2 = 8'h01;
    inicio = 1;
    @(negedge clock);
    chk("b2b first pronto", pronto, 1);
    chk("b2b first result", SaidaULA, 8'h02);
    ULAOp = 3'd4;
    Operando1 = 8'h0F;
    Operando2 = 8'hF0;
    @(negedge clock);
    chk("b2b second pronto", pronto, 1);
    chk("b2b second result", SaidaULA, 8'hFF);
    inicio = 0;
    do_op("invalid", 3'd7, 8'h12, 8'h34, 8'h00, 0, 1, 0, 0, oc);
    repeat (3000) begin
      inicio = ($urandom % 3) != 0;
      ULAOp = 3'($urandom);
      Operando1 = L'($urandom);
      Operando2 = ($urandom % 4 == 0) ? L'($urandom % 3) : L'($urandom);
      @(negedge clock);
    end
    inicio = 0;
    repeat (12) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
